// File: rtl/jkff_driver.sv
// jkff_driver - initiator side of the j/k/q flip-flop interface.
//
// Accepts target q values over a valid/ready handshake and queues them in a
// small FIFO. Each popped target becomes a j/k excitation that is driven for
// exactly one cycle. The q returned by the flip-flop is then compared against
// the target.
//
// Build option:
//   TOGGLE_EXC_EN  defined   -> a state change is excited with j=1,k=1 (toggle)
//                  undefined -> set (j=1,k=0) or reset (j=0,k=1) excitation
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   req_valid/req_q    target request; req_ready = FIFO not full
//   j, k               registered excitation to the flip-flop
//   q                  flip-flop output, sampled in CHECK
//   err_clr            clears err_sticky (a same-cycle mismatch wins)
//   chk_ok/chk_err     one-cycle result pulses
//   err_sticky         latched mismatch flag
//   err_cnt            saturating mismatch count, cleared only by rst
//   level              FIFO occupancy
//   busy               FSM not IDLE or FIFO not empty
module jkff_driver #(
  parameter int   DEPTH  = 4,
  parameter int   CNT_W  = 8,
  parameter logic INIT_Q = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic                     req_q,
  output logic                     req_ready,
  output logic                     j,
  output logic                     k,
  input  logic                     q,
  input  logic                     err_clr,
  output logic                     chk_ok,
  output logic                     chk_err,
  output logic                     err_sticky,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Excitation {j,k} that moves the flip-flop from cur to tgt.
  function automatic logic [1:0] excite(input logic tgt, input logic cur);
    logic [1:0] r;
    r = 2'b00;
    if (tgt == cur) begin
      r = 2'b00;
    end else begin
`ifdef TOGGLE_EXC_EN
      r = 2'b11;
`else
      r = tgt ? 2'b10 : 2'b01;
`endif
    end
    return r;
  endfunction

  state_t          state_r, state_nxt_s;
  logic            mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]   level_r;
  logic            empty_s, full_s, push_s, pop_s;
  logic            head_s;
  logic            tgt_r, exp_q_r;
  logic [1:0]      jk_r, jk_nxt_s;
  logic            ok_nxt_s, err_nxt_s;
  logic            chk_ok_r, chk_err_r, err_sticky_r;
  logic [CNT_W-1:0] err_cnt_r;

  assign empty_s   = (level_r == {LW{1'b0}});
  assign full_s    = (level_r == LW'(DEPTH));
  assign push_s    = req_valid && !full_s;
  assign head_s    = mem_r[rd_ptr_r];

  assign req_ready  = !full_s;
  assign j          = jk_r[1];
  assign k          = jk_r[0];
  assign chk_ok     = chk_ok_r;
  assign chk_err    = chk_err_r;
  assign err_sticky = err_sticky_r;
  assign err_cnt    = err_cnt_r;
  assign level      = level_r;
  assign busy       = (state_r != IDLE) || !empty_s;

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= req_q;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      if (push_s && !pop_s)      level_r <= level_r + LW'(1);
      else if (pop_s && !push_s) level_r <= level_r - LW'(1);
      else                       level_r <= level_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = empty_s ? IDLE : DRIVE;
      DRIVE:   state_nxt_s = CHECK;
      CHECK:   state_nxt_s = empty_s ? IDLE : DRIVE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output logic: pop decision, next excitation and check result.
  // In CHECK the next excitation is relative to tgt_r, because exp_q_r
  // takes that value on the same edge.
  always_comb begin
    pop_s     = 1'b0;
    jk_nxt_s  = 2'b00;
    ok_nxt_s  = 1'b0;
    err_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s    = 1'b1;
          jk_nxt_s = excite(head_s, exp_q_r);
        end else begin
          jk_nxt_s = 2'b00;
        end
      end
      DRIVE: begin
        jk_nxt_s = 2'b00;
      end
      CHECK: begin
        ok_nxt_s  = (q == tgt_r);
        err_nxt_s = (q != tgt_r);
        if (!empty_s) begin
          pop_s    = 1'b1;
          jk_nxt_s = excite(head_s, tgt_r);
        end else begin
          jk_nxt_s = 2'b00;
        end
      end
      default: begin
        jk_nxt_s = 2'b00;
      end
    endcase
  end

  // Registered excitation, expected-value model and check outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jk_r         <= 2'b00;
      tgt_r        <= INIT_Q;
      exp_q_r      <= INIT_Q;
      chk_ok_r     <= 1'b0;
      chk_err_r    <= 1'b0;
      err_sticky_r <= 1'b0;
      err_cnt_r    <= {CNT_W{1'b0}};
    end else begin
      jk_r      <= jk_nxt_s;
      chk_ok_r  <= ok_nxt_s;
      chk_err_r <= err_nxt_s;
      if (pop_s) tgt_r <= head_s;
      // The model tracks the requested target, never the observed q.
      if (state_r == CHECK) exp_q_r <= tgt_r;
      if (err_nxt_s)    err_sticky_r <= 1'b1;
      else if (err_clr) err_sticky_r <= 1'b0;
      else              err_sticky_r <= err_sticky_r;
      if (err_nxt_s && (err_cnt_r != {CNT_W{1'b1}}))
        err_cnt_r <= err_cnt_r + CNT_W'(1);
    end
  end

endmodule
